// File: rtl/segmented_adder.sv
`default_nettype none
// ============================================================================
// Module   : segmented_adder
// Purpose  : Multi-cycle adder/subtractor. The operands are added CHUNK bits
//            per clock, least-significant chunk first, and the carry ripples
//            through a register between cycles. Results are exposed only
//            once the whole word has been processed.
// Ports    : clk_i    - clock; all state changes on the rising edge
//            rst_n_i  - asynchronous active-low reset
//            start_i  - request an operation (accepted in IDLE or DONE)
//            sub_i    - 0 = add, 1 = subtract (A - B)
//            A_i, B_i - operands, WIDTH bits
//            C_i      - carry-in for add; ignored for subtract
//            S_o      - registered result
//            C_o      - registered carry-out of the MSB (1 = no borrow on sub)
//            V_o      - registered two's-complement overflow flag
//            busy_o   - high while in RUN
//            done_o   - one-cycle completion pulse (state DONE)
// Revision : 1.0 - initial release
// ============================================================================
module segmented_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o,
  output logic             V_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;      // already inverted for subtract
  logic [WIDTH-1:0]   sum_q;    // partial sum, never visible on S_o
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;

  logic [31:0]        base_d;
  logic [CHUNK-1:0]   a_chunk_d;
  logic [CHUNK-1:0]   b_chunk_d;
  logic [CHUNK-1:0]   chunk_sum_d;
  logic               carry_d;
  logic [WIDTH-1:0]   sum_d;
  logic               ovf_d;

  // One chunk of the ripple addition, plus the full word as it will look
  // after this cycle's chunk is merged in (used on the completion edge).
  always_comb begin
    base_d      = 32'(idx_q) * CHUNK;
    a_chunk_d   = a_q[base_d +: CHUNK];
    b_chunk_d   = b_q[base_d +: CHUNK];
    {carry_d, chunk_sum_d} = {1'b0, a_chunk_d} + {1'b0, b_chunk_d}
                           + {{CHUNK{1'b0}}, carry_q};
    sum_d       = sum_q;
    sum_d[base_d +: CHUNK] = chunk_sum_d;
    // Carry into the MSB is recovered as a^b^s at that bit position, which
    // works for any CHUNK including 1.
    ovf_d       = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1] ^ carry_d;
  end

  // The add/subtract choice is fully captured by the inverted B and the
  // initial carry, so the operation type itself needs no storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      S_o     <= '0;
      C_o     <= 1'b0;
      V_o     <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            a_q     <= A_i;
            b_q     <= sub_i ? ~B_i : B_i;
            carry_q <= sub_i ? 1'b1 : C_i;
            idx_q   <= '0;
            state_q <= S_RUN;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
          end
        end
        S_RUN: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          if (idx_q == LAST_IDX) begin
            S_o     <= sum_d;
            C_o     <= carry_d;
            V_o     <= ovf_d;
            state_q <= S_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
